mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single synchronous memory port between the core (driven from `control_unit` MemRead/MemWrite and the address/data muxes) and an I/O loader port. Fixed core priority, with an optional starvation guard for the I/O side. Every access is a three-edge request/grant/response sequence ending in a one-cycle done pulse to the owner. The block sits between the datapath memory muxes and the memory macro.

## Interface
- `DATA_W`, 16: data width, both requesters and memory.
- `ADDR_W`, 16: address width.
- `STARVE_MAX`, 4: consecutive core grants, with io_req pending, before I/O is forced. Used only with the guard macro.

- `CLK`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `core_req`  in  1  core access request, level.
- `core_we`  in  1  1 = write, 0 = read.
- `core_addr`  in  ADDR_W  core address.
- `core_wdata`  in  DATA_W  core write data.
- `core_rdata`  out  DATA_W  core read data, registered, held until next core read.
- `core_done`  out  1  one-cycle pulse, core access complete.
- `io_req`, `io_we`, `io_addr`, `io_wdata`  in  1/1/ADDR_W/DATA_W  I/O request fields, same semantics as the core fields.
- `io_rdata`  out  DATA_W  I/O read data, registered, held.
- `io_done`  out  1  one-cycle pulse, I/O access complete.
- `mem_en`, `mem_we`  out  1/1  memory enable and write strobe, registered.
- `mem_addr`, `mem_wdata`  out  ADDR_W/DATA_W  memory address and write data, registered.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after the mem_en edge.

## Operation
- FSM states: IDLE, ACC, RESP. A 1-bit `owner` register records CORE or IO.
- **IDLE**, any req high:
  - Choose the winner.
  - Latch the winner's addr/we/wdata onto the mem_* outputs.
  - Set mem_en=1 and `owner`.
  - Go to ACC.
- **IDLE**, no req: stay in IDLE; mem_en=0.
- **ACC**: clear mem_en and mem_we; go to RESP. The memory performs the access at this edge.
- **RESP**:
  - Read: copy mem_rdata into the owner's rdata register.
  - Raise the owner's done for one cycle.
  - Go to IDLE.
- Write: done pulses; the rdata register is unchanged.
- Priority: core wins when both req are high. The loser's req is simply re-evaluated at the next IDLE.
- Requests are level-sensitive:
  - Each IDLE cycle with req high starts a new access. Back-to-back accesses are legal.
  - A requester must hold its fields stable from req assertion until the grant edge.
  - A requester must drop req by the cycle its done is high if it wants no further access.
- Non-owner done stays 0 throughout.

## Timing
- Reset values:
  - state=IDLE, owner=CORE.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_rdata=0, io_rdata=0.
  - core_done=0, io_done=0.
  - guard counter=0.
- Latency: req sampled high in IDLE at edge E0 → mem_en high E0..E1 → done high E2..E3. Read data is valid in rdata from E2.
- Throughput: one access per 3 cycles; no idle gap for back-to-back requests.
- Reset mid-operation:
  - Returns to reset values at the reset edge; the in-flight access is abandoned and no done pulse is issued.
  - A write whose ACC cycle coincides with the reset edge may commit to memory.
- Simultaneous req from both sides with the guard off: core always granted.

## Configuration
- **`ARB_STARVE_GUARD_EN` defined**:
  - A counter of width clog2(STARVE_MAX+1) increments on each core grant made while io_req is high.
  - When the counter equals STARVE_MAX and both req are high in IDLE, IO is granted.
  - The counter clears on any IO grant, and also on a core grant with io_req low.
  - The counter saturates at STARVE_MAX.
- **Not defined**: strict core priority; STARVE_MAX is ignored; no counter logic is synthesized.

## Test plan
- After reset, core_req=1, core_we=1, core_addr=0x0010, core_wdata=0xBEEF for one access, then a read of 0x0010 → mem_en pulses at E0 then E0+3. The read sets core_done at E2 of the second access and core_rdata=0xBEEF. io_done stays 0.
- io_req only, read 0x0020 preloaded 0x1234 → io_done one cycle at E2 with io_rdata=0x1234. core_rdata stays 0.
- core_req and io_req held high together for 8 accesses, guard off → all 8 grants go to core; io_done never pulses.
- Same stimulus with `ARB_STARVE_GUARD_EN`, STARVE_MAX=4 → grant order core, core, core, core, io, core...
- Reset asserted for one cycle during ACC of a core read → no core_done; mem_en=0 and state IDLE after the edge; core_rdata=0.
- Back-to-back core reads of 0x0001..0x0003 with req held → three core_done pulses exactly 3 cycles apart, each with the matching data.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the request/response and memory-side signals around
//               mem_port_arbiter.
//               slave  - arbiter view: requests and mem_rdata in; responses
//                        and the memory command out.
//               master - requester/memory view, the mirror image.
//               Signals:
//                 core_req/core_we/core_addr/core_wdata  core request fields
//                 core_rdata/core_done                   core response
//                 io_req/io_we/io_addr/io_wdata          I/O request fields
//                 io_rdata/io_done                       I/O response
//                 mem_en/mem_we/mem_addr/mem_wdata       memory command
//                 mem_rdata                              memory read data
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic [DATA_W-1:0] core_rdata;
    logic              core_done;

    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic [DATA_W-1:0] io_rdata;
    logic              io_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        input  io_req, io_we, io_addr, io_wdata,
        input  mem_rdata,
        output core_rdata, core_done, io_rdata, io_done,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        output io_req, io_we, io_addr, io_wdata,
        output mem_rdata,
        input  core_rdata, core_done, io_rdata, io_done,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one synchronous memory port between the core and the
//               I/O loader. Fixed core priority. Every access runs
//               IDLE (grant) -> ACC (memory edge) -> RESP (done pulse).
//               Ports:
//                 CLK    sole clock, rising edge
//                 Reset  synchronous, active-high
//                 bus    mem_port_arbiter_if.slave (requests, responses,
//                        memory command and read data)
//               Optional feature macro: ARB_STARVE_GUARD_EN
//                 When defined, after STARVE_MAX consecutive core grants made
//                 while io_req was pending, the next contested grant goes to
//                 I/O. When undefined, no counter exists and STARVE_MAX is
//                 only range-checked.
//               DATA_W/ADDR_W must match the connected interface instance.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  wire logic          CLK,
    input  wire logic          Reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_IO   = 1'b1;

    generate
        if (STARVE_MAX < 1) begin : g_bad_starve_max
            $error("mem_port_arbiter: STARVE_MAX must be at least 1");
        end
    endgenerate

    state_t            state_q;
    logic              owner_q;
    logic              acc_we_q;     // direction of the access in flight
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] io_rdata_q;
    logic              core_done_q;
    logic              io_done_q;

    logic              w_any_req;
    logic              w_grant_io;

    assign w_any_req = bus.core_req | bus.io_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    // Consecutive core grants taken while I/O was waiting.
    logic [CNT_W-1:0] starve_cnt_q;

    assign w_grant_io = bus.io_req & (~bus.core_req | (starve_cnt_q == CNT_MAX));
`else
    assign w_grant_io = bus.io_req & ~bus.core_req;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_CORE;
            acc_we_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            io_rdata_q   <= '0;
            core_done_q  <= 1'b0;
            io_done_q    <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            // Done is a single-cycle pulse; only RESP raises it.
            core_done_q <= 1'b0;
            io_done_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (w_any_req) begin
                        mem_en_q <= 1'b1;
                        owner_q  <= w_grant_io ? OWNER_IO : OWNER_CORE;
                        state_q  <= ST_ACC;
                        if (w_grant_io) begin
                            mem_we_q    <= bus.io_we;
                            acc_we_q    <= bus.io_we;
                            mem_addr_q  <= bus.io_addr;
                            mem_wdata_q <= bus.io_wdata;
                        end else begin
                            mem_we_q    <= bus.core_we;
                            acc_we_q    <= bus.core_we;
                            mem_addr_q  <= bus.core_addr;
                            mem_wdata_q <= bus.core_wdata;
                        end
`ifdef ARB_STARVE_GUARD_EN
                        if (w_grant_io || !bus.io_req) begin
                            starve_cnt_q <= '0;
                        end else if (starve_cnt_q != CNT_MAX) begin
                            starve_cnt_q <= starve_cnt_q + CNT_W'(1);
                        end
`endif
                    end else begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                    end
                end

                ST_ACC: begin
                    // The memory samples the command on this edge.
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= ST_RESP;
                end

                ST_RESP: begin
                    if (!acc_we_q) begin
                        if (owner_q == OWNER_IO) begin
                            io_rdata_q <= bus.mem_rdata;
                        end else begin
                            core_rdata_q <= bus.mem_rdata;
                        end
                    end
                    if (owner_q == OWNER_IO) begin
                        io_done_q <= 1'b1;
                    end else begin
                        core_done_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_rdata = core_rdata_q;
    assign bus.core_done  = core_done_q;
    assign bus.io_rdata   = io_rdata_q;
    assign bus.io_done    = io_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A 256-word memory
//               macro stand-in answers the memory port; a transaction-level
//               reference model predicts all outputs every cycle. Directed
//               scenarios pin the model with literal values, then randomized
//               requests (with occasional resets) run against the model.
//               Honours ARB_STARVE_GUARD_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_port_arbiter #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    // ---------------- memory macro stand-in (environment) ----------------
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];
    logic [15:0] mem_rdata_r = 16'h0;
    assign bus.mem_rdata = mem_rdata_r;

    function automatic logic [15:0] preload(input int i);
        case (i)
            1:       return 16'h1111;
            2:       return 16'h2222;
            3:       return 16'h3333;
            8'h20:   return 16'h1234;
            default: return 16'(i * 16'h0101) ^ 16'hA5A5;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = preload(i);
            ref_mem[i] = preload(i);
        end
    end

    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else                     mem_rdata_r <= mem[bus.mem_addr[7:0]];
        end
    end

    // ---------------- transaction-level reference model ----------------
    // age: -1 = port free, 0 = one edge after grant, 1 = two edges after grant.
    int          age = -1;
    int          exp_starve = 0;
    logic        t_io = 1'b0;
    logic        t_we = 1'b0;
    logic [15:0] t_rd = 16'h0;
    logic        exp_mem_en = 1'b0, exp_mem_we = 1'b0;
    logic [15:0] exp_mem_addr = 16'h0, exp_mem_wdata = 16'h0;
    logic [15:0] exp_core_rdata = 16'h0, exp_io_rdata = 16'h0;
    logic        exp_core_done = 1'b0, exp_io_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            age = -1; exp_starve = 0;
            exp_mem_en = 1'b0; exp_mem_we = 1'b0;
            exp_mem_addr = 16'h0; exp_mem_wdata = 16'h0;
            exp_core_rdata = 16'h0; exp_io_rdata = 16'h0;
            exp_core_done = 1'b0; exp_io_done = 1'b0;
        end else begin
            exp_core_done = 1'b0;
            exp_io_done   = 1'b0;
            if (age == 0) begin
                exp_mem_en = 1'b0; exp_mem_we = 1'b0;
                age = 1;
            end else if (age == 1) begin
                if (!t_we) begin
                    if (t_io) exp_io_rdata = t_rd;
                    else      exp_core_rdata = t_rd;
                end
                if (t_io) exp_io_done = 1'b1;
                else      exp_core_done = 1'b1;
                age = -1;
            end else if (bus.core_req || bus.io_req) begin
                t_io = bus.io_req && !bus.core_req;
`ifdef ARB_STARVE_GUARD_EN
                if (bus.io_req && bus.core_req && exp_starve == STARVE_MAX) t_io = 1'b1;
                if (t_io || !bus.io_req)           exp_starve = 0;
                else if (exp_starve < STARVE_MAX)  exp_starve = exp_starve + 1;
`endif
                t_we          = t_io ? bus.io_we    : bus.core_we;
                exp_mem_addr  = t_io ? bus.io_addr  : bus.core_addr;
                exp_mem_wdata = t_io ? bus.io_wdata : bus.core_wdata;
                exp_mem_en    = 1'b1;
                exp_mem_we    = t_we;
                if (t_we) ref_mem[exp_mem_addr[7:0]] = exp_mem_wdata;
                else      t_rd = ref_mem[exp_mem_addr[7:0]];
                age = 0;
            end else begin
                exp_mem_en = 1'b0; exp_mem_we = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        check("cycle_outputs",
              {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
               bus.core_done, bus.io_done, bus.core_rdata, bus.io_rdata},
              {exp_mem_en, exp_mem_we, exp_mem_addr, exp_mem_wdata,
               exp_core_done, exp_io_done, exp_core_rdata, exp_io_rdata});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.io_req   = 1'b0; bus.io_we   = 1'b0; bus.io_addr   = '0; bus.io_wdata   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0]  order;
    int          ndone;
    int          t_done [0:2];
    logic [15:0] b2b_exp [0:2];
    logic [7:0]  exp_order;
    int          exp_core_cnt;
    bit          seen;

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_state",
              {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
               bus.core_done, bus.io_done, bus.core_rdata, bus.io_rdata}, 68'h0);

        // Core write 0x0010 <= 0xBEEF, then read it back.
        bus.core_req = 1'b1; bus.core_we = 1'b1;
        bus.core_addr = 16'h0010; bus.core_wdata = 16'hBEEF;
        @(negedge clk);
        check("wr_mem_en_E0", 68'(bus.mem_en), 68'h1);
        check("wr_mem_addr", 68'(bus.mem_addr), 68'h0010);
        check("wr_mem_wdata", 68'(bus.mem_wdata), 68'hBEEF);
        repeat (2) @(negedge clk);
        check("wr_core_done_E2", 68'(bus.core_done), 68'h1);
        bus.core_we = 1'b0; bus.core_wdata = 16'h0;
        @(negedge clk);
        check("rd_mem_en_E0p3", 68'({bus.mem_en, bus.mem_we}), 68'h2);
        repeat (2) @(negedge clk);
        check("rd_core_done", 68'(bus.core_done), 68'h1);
        check("rd_core_rdata", 68'(bus.core_rdata), 68'hBEEF);
        check("rd_io_done_low", 68'(bus.io_done), 68'h0);
        bus.core_req = 1'b0;
        @(negedge clk);
        check("core_done_one_cycle", 68'(bus.core_done), 68'h0);

        // I/O read of preloaded 0x0020.
        do_reset();
        bus.io_req = 1'b1; bus.io_we = 1'b0; bus.io_addr = 16'h0020;
        repeat (3) @(negedge clk);
        check("io_done", 68'(bus.io_done), 68'h1);
        check("io_rdata", 68'(bus.io_rdata), 68'h1234);
        check("io_core_rdata_zero", 68'(bus.core_rdata), 68'h0);
        bus.io_req = 1'b0;
        @(negedge clk);
        check("io_done_one_cycle", 68'(bus.io_done), 68'h0);

        // Both requesters held high for 8 accesses.
        do_reset();
        bus.core_req = 1'b1; bus.core_addr = 16'h0030;
        bus.io_req   = 1'b1; bus.io_addr   = 16'h0040;
        order = 8'h0; ndone = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.core_done === 1'b1 || bus.io_done === 1'b1) begin
                if (ndone < 8) order[ndone] = bus.io_done;
                ndone++;
            end
        end
        idle_inputs();
`ifdef ARB_STARVE_GUARD_EN
        exp_order = 8'b0001_0000;
`else
        exp_order = 8'b0000_0000;
`endif
        check("contend_done_count", 68'(ndone), 68'd8);
        check("contend_grant_order", 68'(order), 68'(exp_order));
        exp_core_cnt = 0;
        for (int i = 0; i < 8; i++) if (!exp_order[i]) exp_core_cnt++;
        check("contend_core_grants", 68'(8 - $countones(order)), 68'(exp_core_cnt));

        // Reset during ACC of a core read.
        do_reset();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 16'h0010;
        @(negedge clk);
        rst = 1'b1; bus.core_req = 1'b0;
        @(negedge clk);
        check("rst_acc_outputs",
              68'({bus.mem_en, bus.core_done, bus.core_rdata}), 68'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_acc_no_done", 68'({bus.core_done, bus.mem_en, bus.core_rdata}), 68'h0);

        // Back-to-back core reads of 0x0001..0x0003.
        do_reset();
        b2b_exp[0] = 16'h1111; b2b_exp[1] = 16'h2222; b2b_exp[2] = 16'h3333;
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 16'h0001;
        for (int k = 0; k < 3; k++) begin
            seen = 1'b0;
            for (int w = 0; w < 6 && !seen; w++) begin
                @(negedge clk);
                if (bus.core_done === 1'b1) seen = 1'b1;
            end
            if (!seen) begin
                check("b2b_timeout", 68'h0, 68'h1);
                t_done[k] = 0;
            end else begin
                t_done[k] = cyc;
                check("b2b_rdata", 68'(bus.core_rdata), 68'(b2b_exp[k]));
            end
            if (k < 2) bus.core_addr = 16'(k + 2);
            else       bus.core_req  = 1'b0;
        end
        check("b2b_spacing_1", 68'(t_done[1] - t_done[0]), 68'd3);
        check("b2b_spacing_2", 68'(t_done[2] - t_done[1]), 68'd3);

        // Randomized traffic with occasional resets.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if (!bus.core_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.core_req = 1'b1; bus.core_we = 1'($urandom);
                    bus.core_addr = 16'($urandom); bus.core_wdata = 16'($urandom);
                end
            end else if (bus.core_done === 1'b1) begin
                if ($urandom_range(0, 2) == 0) bus.core_req = 1'b0;
                bus.core_we = 1'($urandom);
                bus.core_addr = 16'($urandom); bus.core_wdata = 16'($urandom);
            end
            if (!bus.io_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.io_req = 1'b1; bus.io_we = 1'($urandom);
                    bus.io_addr = 16'($urandom); bus.io_wdata = 16'($urandom);
                end
            end else if (bus.io_done === 1'b1) begin
                if ($urandom_range(0, 2) == 0) bus.io_req = 1'b0;
                bus.io_we = 1'($urandom);
                bus.io_addr = 16'($urandom); bus.io_wdata = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                bus.io_req = 1'b0;
            end
        end
        rst = 1'b0;
        idle_inputs();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
